logicnets_in_packer: RTL and testbench

Streaming input stage for the layer-0 LogicNets neuron array. It accepts one signed readout sample per cycle and quantizes each sample to a QBITS-bit code. It packs NUM_FEAT consecutive codes into the flat feature vector from which every layer-0 neuron slices its inputs. Capture and output are double-buffered, so the next frame can fill while layer 0 or its consumer stalls.

---
 rtl/logicnets_in_pkg.sv | 16 +
 rtl/logicnets_in_quant.sv | 40 ++++
 rtl/logicnets_in_packer.sv | 151 +++++++++++++++
 tb/tb_logicnets_in_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logicnets_in_pkg.sv
// Shared defaults, frame-index width and capture FSM encoding for the
// LogicNets layer-0 input packer.
package logicnets_in_pkg;

  localparam int LN_IN_W     = 12;
  localparam int LN_QBITS    = 2;
  localparam int LN_NUM_FEAT = 32;
  localparam int LN_SHIFT    = 8;
  localparam int LN_IDX_W    = $clog2(LN_NUM_FEAT);

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } cap_state_t;

endpackage

// File: rtl/logicnets_in_quant.sv
// Combinational sample quantizer: arithmetic shift, offset to unsigned,
// clamp to the QBITS code range, and flag when clamping occurred.
module logicnets_in_quant
  import logicnets_in_pkg::*;
#(
  parameter int IN_W  = LN_IN_W,
  parameter int QBITS = LN_QBITS,
  parameter int SHIFT = LN_SHIFT
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [QBITS-1:0] o_code,
  output logic             o_clamped
);

  localparam logic signed [IN_W:0] C_OFF = (IN_W+1)'(2 ** (QBITS - 1));
  localparam logic signed [IN_W:0] C_MAX = (IN_W+1)'(2 ** QBITS - 1);

  logic signed [IN_W-1:0] w_s;
  logic signed [IN_W:0]   w_c;
  logic                   w_lo;
  logic                   w_hi;

  // One extra bit of headroom keeps the offset add from overflowing.
  assign w_s  = $signed(i_data) >>> SHIFT;
  assign w_c  = $signed({w_s[IN_W-1], w_s}) + C_OFF;
  assign w_lo = w_c[IN_W];
  assign w_hi = (w_c > C_MAX);

  always_comb begin
    o_code = w_c[QBITS-1:0];
    if (w_lo) begin
      o_code = '0;
    end else if (w_hi) begin
      o_code = '1;
    end
  end

  assign o_clamped = w_lo | w_hi;

endmodule

// File: rtl/logicnets_in_packer.sv
// Double-buffered input packer: quantizes a sample stream into NUM_FEAT codes per frame.
// Optional macro LOGICNETS_IN_SATCNT_EN adds a saturating clamp counter output sat_count.
module logicnets_in_packer
  import logicnets_in_pkg::*;
#(
  parameter int IN_W     = LN_IN_W,
  parameter int QBITS    = LN_QBITS,
  parameter int NUM_FEAT = LN_NUM_FEAT,
  parameter int SHIFT    = LN_SHIFT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_FEAT*QBITS-1:0] out_data,
  output logic                      err_frame
`ifdef LOGICNETS_IN_SATCNT_EN
  ,
  output logic [15:0]               sat_count
`endif
);

  localparam int VEC_W = NUM_FEAT * QBITS;
  localparam int IDX_W = (NUM_FEAT == LN_NUM_FEAT) ? LN_IDX_W : $clog2(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  cap_state_t       r_state;
  cap_state_t       w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [VEC_W-1:0] r_cap;
  logic [VEC_W-1:0] w_cap_next;
  logic [VEC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             w_out_valid_next;
  logic             r_in_ready;
  logic             r_err;
  logic             w_err_next;
  logic [QBITS-1:0] w_code;
  logic             w_clamped;
  logic             w_accept;
  logic             w_out_fire;
  logic             w_complete;
  logic             w_load_out;

  logicnets_in_quant #(
    .IN_W (IN_W),
    .QBITS(QBITS),
    .SHIFT(SHIFT)
  ) u_quant (
    .i_data   (in_data),
    .o_code   (w_code),
    .o_clamped(w_clamped)
  );

  assign w_accept   = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_complete = w_accept && (r_idx == LAST_IDX);

  // Capture view including the code being accepted this cycle, so a
  // completing beat can go straight to the output slot.
  generate
    for (genvar gi = 0; gi < NUM_FEAT; gi++) begin : g_slot
      assign w_cap_next[gi*QBITS +: QBITS] =
        (w_accept && (r_idx == IDX_W'(gi))) ? w_code : r_cap[gi*QBITS +: QBITS];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_load_out   = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_complete) begin
          if (!r_out_valid || w_out_fire) begin
            w_load_out = 1'b1;
          end else begin
            w_state_next = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (w_out_fire) begin
          w_load_out   = 1'b1;
          w_state_next = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_comb begin
    w_out_valid_next = r_out_valid;
    if (w_load_out) begin
      w_out_valid_next = 1'b1;
    end else if (w_out_fire) begin
      w_out_valid_next = 1'b0;
    end
    w_idx_next = r_idx;
    if (w_accept) begin
      w_idx_next = (w_complete || in_last) ? '0 : r_idx + IDX_W'(1);
    end
    w_err_next = w_accept && (w_complete ? !in_last : in_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_idx       <= '0;
      r_cap       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_cap       <= w_cap_next;
      r_out_valid <= w_out_valid_next;
      r_in_ready  <= (w_state_next == ST_FILL);
      r_err       <= w_err_next;
      if (w_load_out) begin
        r_out_data <= w_cap_next;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err_frame = r_err;

`ifdef LOGICNETS_IN_SATCNT_EN
  logic [15:0] r_sat_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (w_accept && w_clamped && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_logicnets_in_packer.sv
// Self-checking bench for logicnets_in_packer: directed scenarios plus random
// traffic checked against a frame-level reference model.
module tb_logicnets_in_packer;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        err_frame;
`ifdef LOGICNETS_IN_SATCNT_EN
  logic [15:0] sat_count;
`endif

  logic fix_ready = 1'b0;
  logic rnd_ready = 1'b0;
  logic rand_ready = 1'b0;
  assign out_ready = rand_ready ? rnd_ready : fix_ready;

  always #5 clk = ~clk;

  logicnets_in_packer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_frame(err_frame)
`ifdef LOGICNETS_IN_SATCNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: frame-level behaviour from the quantization rule.
  logic [11:0] fdata[N];
  int          m_codes[N];
  int          m_idx = 0;
  logic [63:0] exp_q[$];
  int          err_exp = 0;
  int          err_seen = 0;
  bit          b2b_mode = 0;
  int          ready_drops = 0;

  function automatic int quantize(input logic [11:0] d);
    int x, s, c;
    x = $signed(d);
    s = x / 256;
    if (x < 0 && (x % 256) != 0) s = s - 1;
    c = s + 2;
    if (c < 0) c = 0;
    if (c > 3) c = 3;
    return c;
  endfunction

  task automatic model_accept(input logic [11:0] d, input logic last);
    logic [63:0] v;
    m_codes[m_idx] = quantize(d);
    if (m_idx == N - 1) begin
      v = '0;
      for (int k = 0; k < N; k++) v[k*2 +: 2] = 2'(m_codes[k]);
      exp_q.push_back(v);
      if (!last) err_exp++;
      m_idx = 0;
    end else if (last) begin
      err_exp++;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input logic [11:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, last);
    @(negedge clk);
  endtask

  task automatic send_frame(input int n, input bit last_on_end, input bit gaps, input bit keep);
    for (int b = 0; b < n; b++) begin
      if (!keep) fdata[b] = 12'($urandom_range(0, 4095));
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      beat(fdata[b], last_on_end && (b == n - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) rnd_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard vectors, hold stability, error pulses.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (err_frame) err_seen++;
      if (b2b_mode && !in_ready) ready_drops++;
      if (prev_stall) chk("hold", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_vec", 64'(out_valid), 64'd0);
        else chk("vector", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int wait_n;
    logic [63:0] held;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", 64'(err_frame), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 1);

    // Quantizer corners in features 0..3
    fix_ready = 1'b1;
    for (int b = 0; b < N; b++) fdata[b] = 12'($urandom_range(0, 4095));
    fdata[0] = 12'h000; fdata[1] = 12'h7FF; fdata[2] = 12'h800; fdata[3] = 12'hF00;
    send_frame(N, 1, 0, 1);
    chk("corner_lat", 64'(out_valid), 1);
    chk("corner_codes", 64'(out_data[7:0]), 64'h4E);
    @(negedge clk);

    // Back-to-back frames
    b2b_mode = 1;
    for (int f = 0; f < 3; f++) begin
      send_frame(N, 1, 0, 0);
      chk("b2b_lat", 64'(out_valid), 1);
    end
    @(negedge clk);
    b2b_mode = 0;
    chk("b2b_one_cycle", 64'(out_valid), 0);
    chk("b2b_ready_drops", 64'(ready_drops), 0);

    // Backpressure
    fix_ready = 1'b0;
    send_frame(N, 1, 0, 0);
    chk("bp_valid1", 64'(out_valid), 1);
    held = exp_q[0];
    send_frame(N, 1, 0, 0);
    chk("bp_pend_ready", 64'(in_ready), 0);
    repeat (3) @(negedge clk);
    chk("bp_stall_data", out_data, held);
    fix_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid2", 64'(out_valid), 1);
    chk("bp_ready_back", 64'(in_ready), 1);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 0);

    // Early last on idx 10
    send_frame(11, 1, 0, 0);
    chk("early_err", 64'(err_frame), 1);
    chk("early_no_vec", 64'(out_valid), 0);
    @(negedge clk);
    chk("early_err_pulse", 64'(err_frame), 0);
    send_frame(N, 1, 0, 0);
    chk("early_next_lat", 64'(out_valid), 1);
    @(negedge clk);

    // Missing last
    send_frame(N, 0, 0, 0);
    chk("miss_err", 64'(err_frame), 1);
    chk("miss_vec", 64'(out_valid), 1);
    @(negedge clk);

    // Reset mid-frame with a vector already held
    fix_ready = 1'b0;
    send_frame(N, 1, 0, 0);
    send_frame(20, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_ready", 64'(in_ready), 0);
    exp_q.delete();
    m_idx = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fix_ready = 1'b1;
    send_frame(N, 1, 0, 0);
    chk("post_rst_lat", 64'(out_valid), 1);
    @(negedge clk);

    // Random traffic with gaps and random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 5; f++) send_frame(N, 1, 1, 0);
    rand_ready = 1'b0;
    fix_ready  = 1'b1;
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    repeat (2) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 0);
    chk("err_count", 64'(err_seen), 64'(err_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
